// File: rtl/gf_poly_mult_seq.sv
// Bit-serial carry-less GF(2)[x] multiplier: one multiplier bit per clock.
// Emits the unreduced product together with the clamped field degree.
module gf_poly_mult_seq #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         a_in,
    input  logic [DATA_WIDTH-1:0]         b_in,
    input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*DATA_WIDTH-1:0]       prod_out,
    output logic [$clog2(DATA_WIDTH):0]   grade_out
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned GW = $clog2(W) + 1;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned PW = 2 * W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   m_reg;

    logic [GW-1:0]   m_eff;
    logic [W-1:0]    op_mask;
    logic [PW-1:0]   partial;
    logic [PW-1:0]   acc_next;
    logic            last;

    assign in_ready = (state == IDLE);

    // Degree clamp, operand mask and the shifted partial product for this step
    always_comb begin
        m_eff    = (polyn_grade > GW'(W)) ? GW'(W) : polyn_grade;
        op_mask  = ~({W{1'b1}} << m_eff);
        partial  = b_reg[cnt] ? (PW'(a_reg) << cnt) : '0;
        acc_next = acc ^ partial;
        last     = (GW'(cnt) == (m_reg - GW'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = (m_eff == '0) ? HOLD : MULT;
            MULT: if (last) state_next = HOLD;
            HOLD: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, accumulation and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            m_reg     <= '0;
            prod_out  <= '0;
            grade_out <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a_in & op_mask;
                        b_reg     <= b_in & op_mask;
                        m_reg     <= m_eff;
                        grade_out <= m_eff;
                        acc       <= '0;
                        cnt       <= '0;
                        // Zero-degree field: nothing to multiply, product is 0
                        if (m_eff == '0) begin
                            prod_out  <= '0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        prod_out  <= acc_next;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
